// File: rtl/add_acc_pipe.sv
// rtl/add_acc_pipe.sv - 2-stage pipelined adder/accumulator with valid/ready handshakes
module add_acc_pipe #(
    parameter int WIDTH       = 8,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             carry
);

    localparam int MSB = WIDTH - 1;

    logic             v1, v2;
    logic             en1, en2;
    logic [WIDTH-1:0] a_q, b_q;
    logic             acc_mode_q, acc_clr_q, sat_en_q;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] op_x, op_y;
    logic [WIDTH:0]   raw;
    logic             ovf_c;
    logic [WIDTH-1:0] sum_c;

    // Integrator-facing documentation only; the sat_en port decides behaviour.
    logic sat_default_unused;
    assign sat_default_unused = SAT_DEFAULT;

    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_mode_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            sat_en_q   <= 1'b0;
        end else if (en1) begin
            v1         <= in_valid;
            a_q        <= a;
            b_q        <= b;
            acc_mode_q <= acc_mode;
            acc_clr_q  <= acc_clr;
            sat_en_q   <= sat_en;
        end
    end

    always_comb begin
        op_x = a_q;
        if (!acc_mode_q)
            op_y = b_q;
        else if (acc_clr_q)
            op_y = '0;
        else
            op_y = acc;
        raw   = {1'b0, op_x} + {1'b0, op_y};
        ovf_c = (op_x[MSB] == op_y[MSB]) && (raw[MSB] != op_x[MSB]);
        sum_c = raw[WIDTH-1:0];
        // Clamp toward the sign of the operands when the signed add wraps.
        if (sat_en_q && ovf_c)
            sum_c = op_x[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            sum      <= '0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            acc      <= '0;
        end else if (en2) begin
            v2       <= v1;
            sum      <= sum_c;
            overflow <= ovf_c;
            carry    <= raw[WIDTH];
            if (v1 && acc_mode_q)
                acc <= sum_c;
        end
    end

endmodule
